ahb_sram_ctrl: RTL and testbench

Parametrised AHB-Lite SRAM slave that replaces the fixed single-port RAM behind the JTAG-to-AHB bridge. It decodes the AHB address and data phases properly, supports byte, halfword and word writes via HSIZE, inserts a configurable number of wait states, and forwards back-to-back write data to a following read. An optional ERROR response covers out-of-range and oversize accesses. It sits on the AHB side of the JTAG debug path as the memory target for the bridge.

---
 rtl/ahb_sram_ctrl_if.sv | 26 ++
 rtl/ahb_sram_ctrl.sv | 144 ++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite bus bundle between a master/interconnect and ahb_sram_ctrl.
interface ahb_sram_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [DATA_W-1:0] HRDATA;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite SRAM slave with byte/half/word writes, wait states and write-to-read forwarding.
// Define AHB_SRAM_ERR_RESP_EN for ERROR responses on out-of-range or oversize accesses.
module ahb_sram_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  ahb_sram_ctrl_if.slave ahb
);
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NBYTES-1:0]   be_q, be_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                req_err;
  logic [IDX_W-1:0]    req_idx;
  logic [LANE_W-1:0]   req_lane;
  logic [2:0]          size_eff;
  logic [NBYTES-1:0]   req_be;
  logic                commit;
  logic                load_rd;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   rd_word;
  logic                unused_bits;

  assign accept   = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign req_idx  = ahb.HADDR[LANE_W +: IDX_W];
  assign req_lane = ahb.HADDR[LANE_W-1:0];
  assign size_eff = (ahb.HSIZE > 3'(LANE_W)) ? 3'(LANE_W) : ahb.HSIZE;
  assign commit   = (state_q == ST_DATA) && write_q;
  assign unused_bits = ^{ahb.HTRANS[0], ahb.HADDR};

`ifdef AHB_SRAM_ERR_RESP_EN
  assign req_err = ((ahb.HADDR >> (LANE_W + IDX_W)) != '0) || (ahb.HSIZE > 3'(LANE_W));
`else
  assign req_err = 1'b0;
`endif

  // A lane is enabled when it falls in the same size-aligned block as the start lane.
  always_comb begin
    req_be = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      req_be[b] = ((b >> size_eff) == (32'(req_lane) >> size_eff));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    rdata_d = rdata_q;
    load_rd = 1'b0;
    rd_idx  = idx_q;

    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_DATA;
          load_rd = !write_q;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          idx_d   = req_idx;
          be_d    = req_be;
          write_d = ahb.HWRITE;
          if (req_err) begin
            state_d = ST_ERR1;
            rdata_d = '0;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
            load_rd = !ahb.HWRITE;
            rd_idx  = req_idx;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
      end
    endcase

    // Merge in the write retiring on this same edge so a back-to-back read sees it.
    rd_word = mem[rd_idx];
    if (commit && (rd_idx == idx_q)) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (be_q[b]) rd_word[8*b +: 8] = ahb.HWDATA[8*b +: 8];
      end
    end
    if (load_rd) rdata_d = rd_word;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= ahb.HWDATA[8*b +: 8];
      end
    end
  end

  assign ahb.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign ahb.HRDATA    = rdata_q;
`ifdef AHB_SRAM_ERR_RESP_EN
  assign ahb.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
  assign ahb.HRESP     = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Randomized bench for ahb_sram_ctrl: a zero-wait and a two-wait instance behind a shared bus,
// checked against a byte-array memory model.
module tb_ahb_sram_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 1024;

  typedef struct {
    int unsigned kind;   // 0 transfer, 1 IDLE, 2 BUSY, 3 unselected NONSEQ
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic        sel2;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  ahb_sram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  ahb_sram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

  ahb_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(if0));
  ahb_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(if2));

  assign if0.HSEL   = hsel & ~sel2;
  assign if2.HSEL   = hsel & sel2;
  assign if0.HADDR  = haddr;   assign if2.HADDR  = haddr;
  assign if0.HTRANS = htrans;  assign if2.HTRANS = htrans;
  assign if0.HWRITE = hwrite;  assign if2.HWRITE = hwrite;
  assign if0.HSIZE  = hsize;   assign if2.HSIZE  = hsize;
  assign if0.HWDATA = hwdata;  assign if2.HWDATA = hwdata;
  assign if0.HREADY = hready;  assign if2.HREADY = hready;
  assign hready = sel2 ? if2.HREADYOUT : if0.HREADYOUT;
  assign hresp  = sel2 ? if2.HRESP     : if0.HRESP;
  assign hrdata = sel2 ? if2.HRDATA    : if0.HRDATA;

  logic [7:0]  mref [2][4096];
  xfer_t       q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(int unsigned kind, logic [31:0] addr, logic wr,
                               logic [2:0] size, logic [31:0] data);
    xfer_t t;
    t.kind = kind; t.addr = addr; t.wr = wr; t.size = size; t.data = data;
    return t;
  endfunction

  function automatic bit xfer_err(xfer_t t);
`ifdef AHB_SRAM_ERR_RESP_EN
    return (t.addr >= 32'h1000) || (t.size > 3'd2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic retire(xfer_t t, int unsigned waits, logic resp, logic [31:0] rdata);
    bit          err;
    int unsigned base, sz, nb, first;
    logic [31:0] exp;
    err   = xfer_err(t);
    base  = ((t.addr / 4) % DEPTH) * 4;
    sz    = (t.size > 3'd2) ? 2 : int'(t.size);
    nb    = 1 << sz;
    first = ((t.addr % 4) / nb) * nb;
    exp   = '0;
    check("resp", 32'(resp), 32'(err));
    check("waits", waits, err ? 1 : (sel2 ? 2 : 0));
    if (t.wr) begin
      if (!err)
        for (int unsigned k = first; k < first + nb; k++) mref[sel2][base + k] = t.data[8*k +: 8];
    end else begin
      if (!err)
        for (int unsigned k = 0; k < 4; k++) exp[8*k +: 8] = mref[sel2][base + k];
      check("rdata", rdata, exp);
    end
  endtask

  task automatic drive_ap(bit v, xfer_t t);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = $urandom; hsize = 3'd2;
    if (v) begin
      haddr = t.addr; hwrite = t.wr; hsize = t.size;
      case (t.kind)
        0:       begin hsel = 1'b1; htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11; end
        1:       begin hsel = 1'b1; htrans = 2'b00; end
        2:       begin hsel = 1'b1; htrans = 2'b01; end
        default: begin hsel = 1'b0; htrans = 2'b10; end
      endcase
    end
  endtask

  // Plays the queue as a pipelined AHB master; call at posedge+1 with the bus idle.
  task automatic run_queue();
    xfer_t       ap, dp;
    bit          ap_v, dp_v, acc;
    logic        rdy, rsp;
    logic [31:0] rd;
    int unsigned waits, budget;
    ap_v = 0; dp_v = 0; waits = 0; budget = 0;
    ap = mk(1, '0, 1'b0, 3'd0, '0);
    dp = ap;
    while ((q.size() > 0 || ap_v || dp_v) && budget < 20000) begin
      if (!ap_v && q.size() > 0) begin
        ap = q.pop_front(); ap_v = 1; drive_ap(1, ap);
      end else if (!ap_v) begin
        drive_ap(0, ap);
      end
      @(negedge HCLK);
      rdy = hready; rsp = hresp; rd = hrdata;
      if (dp_v) begin
        if (rdy) begin
          retire(dp, waits, rsp, rd);
          dp_v = 0;
        end else begin
          check("wait_resp", 32'(rsp), 32'(xfer_err(dp)));
          waits++;
        end
      end else begin
        check("idle_rdy", 32'(rdy), 32'd1);
        check("idle_resp", 32'(rsp), 32'd0);
      end
      acc = ap_v && rdy;
      @(posedge HCLK); #1;
      if (acc) begin
        if (ap.kind == 0) begin dp = ap; dp_v = 1; waits = 0; end
        ap_v = 0;
      end
      hwdata = (dp_v && dp.wr) ? dp.data : $urandom;
      budget++;
    end
    check("queue_drain", q.size() + 32'(ap_v) + 32'(dp_v), 32'd0);
  endtask

  task automatic add_preload();
    for (int unsigned w = 0; w < 64; w++) q.push_back(mk(0, 32'(w * 4), 1'b1, 3'd2, $urandom));
  endtask

  task automatic add_rand(int unsigned n);
    xfer_t       t;
    int unsigned r;
    for (int unsigned i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      t.kind = (r < 70) ? 0 : (r < 80) ? 1 : (r < 90) ? 2 : 3;
      t.addr = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) t.addr = t.addr + 32'h1000 * $urandom_range(1, 3);
      t.wr   = 1'($urandom_range(0, 1));
      t.size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      t.data = $urandom;
      q.push_back(t);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    xfer_t w;
    HRESETn = 1'b0; sel2 = 1'b0; hwdata = '0;
    drive_ap(0, mk(1, '0, 1'b0, 3'd0, '0));
    #12;
    check("rst_rdy0",   32'(if0.HREADYOUT), 32'd1);
    check("rst_resp0",  32'(if0.HRESP),     32'd0);
    check("rst_rdata0", if0.HRDATA,         32'd0);
    check("rst_rdy2",   32'(if2.HREADYOUT), 32'd1);
    check("rst_rdata2", if2.HRDATA,         32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Zero-wait instance: forwarding, byte lanes, wrap/error, IDLE/BUSY, then random.
    add_preload();
    q.push_back(mk(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
    q.push_back(mk(0, 32'h10, 1'b0, 3'd2, '0));
    q.push_back(mk(0, 32'h20, 1'b1, 3'd2, 32'h11223344));
    q.push_back(mk(0, 32'h21, 1'b1, 3'd0, 32'h0000AA00));
    q.push_back(mk(0, 32'h20, 1'b0, 3'd2, '0));
    q.push_back(mk(0, 32'h1000, 1'b1, 3'd2, 32'hCAFEF00D));
    q.push_back(mk(0, 32'h0, 1'b0, 3'd2, '0));
    q.push_back(mk(0, 32'h1000, 1'b0, 3'd2, '0));
    q.push_back(mk(1, 32'h30, 1'b1, 3'd2, 32'h12345678));
    q.push_back(mk(2, 32'h30, 1'b1, 3'd2, 32'h87654321));
    q.push_back(mk(0, 32'h30, 1'b0, 3'd2, '0));
    add_rand(300);
    run_queue();

    // Two-wait instance: held address phases, reset mid-write, then random.
    sel2 = 1'b1;
    add_preload();
    q.push_back(mk(0, 32'h14, 1'b1, 3'd2, 32'h5A5A5A5A));
    q.push_back(mk(0, 32'h18, 1'b0, 3'd2, '0));
    q.push_back(mk(0, 32'h14, 1'b0, 3'd2, '0));
    run_queue();

    w = mk(0, 32'h14, 1'b1, 3'd2, 32'h0BADF00D);
    drive_ap(1, w);
    @(posedge HCLK); #1;
    drive_ap(0, w); hwdata = w.data;
    check("rst_pre_rdy",   32'(hready), 32'd0);
    check("rst_pre_rdata", hrdata,      32'h5A5A5A5A);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_mid_rdy",   32'(hready), 32'd1);
    check("rst_mid_resp",  32'(hresp),  32'd0);
    check("rst_mid_rdata", hrdata,      32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    q.push_back(mk(0, 32'h14, 1'b0, 3'd2, '0));
    add_rand(200);
    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
